led_matrix_pwm_driver: RTL and testbench

- Row-scanning driver for multiplexed bi-colour LED matrices. Generalises the fixed 16x16 on/off driver to ROWS x COLS with per-pixel BPP-bit brightness, using bit-slot PWM.
- Holds a double-buffered frame: a pending buffer is loaded by valid/ready handshake and swapped into the active buffer only at a frame boundary, so frames never tear.
- Sits between game/graphics logic and a board-level wrapper that maps row_sel/red_col/grn_col onto GPIO_1.

---
 rtl/led_matrix_pwm_driver.sv | 178 +++++++++++++++++
 tb/tb_led_matrix_pwm_driver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_pwm_driver.sv
// led_matrix_pwm_driver
// Row-scanning driver for multiplexed bi-colour LED matrices with per-pixel
// BPP-bit brightness (bit-slot PWM) and a double-buffered frame store.
// Optional feature macro: LED_ROW_BLANK_EN -- inserts BLANK_CYCLES of column
// blanking after every row to suppress ghosting. Without it row_blank is 0
// and the row advances straight after its last PWM slot.
module led_matrix_pwm_driver #(
  parameter int ROWS         = 16,
  parameter int COLS         = 16,
  parameter int BPP          = 2,
  parameter int FREQDIV      = 0,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      frame_valid,
  output logic                      frame_ready,
  input  logic [ROWS*COLS*BPP-1:0]  red_in,
  input  logic [ROWS*COLS*BPP-1:0]  grn_in,
  output logic [$clog2(ROWS)-1:0]   row_sel,
  output logic [COLS-1:0]           red_col,
  output logic [COLS-1:0]           grn_col,
  output logic                      row_blank,
  output logic                      frame_start
);

  localparam int PIX_BITS = ROWS * COLS * BPP;
  localparam int RW       = $clog2(ROWS);
  // A zero-width tick counter is modelled as a 1-bit counter pinned at 0.
  localparam int TW       = (FREQDIV > 0) ? FREQDIV : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'((1 << FREQDIV) - 1);
  localparam logic [BPP-1:0] SLOT_LAST = BPP'((1 << BPP) - 2);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(ROWS - 1);

  // Elaboration-time parameter sanity checks.
  if (ROWS < 2) begin : g_bad_rows
    $error("led_matrix_pwm_driver: ROWS must be at least 2");
  end
  if (BPP < 1 || BPP > 4) begin : g_bad_bpp
    $error("led_matrix_pwm_driver: BPP must be in 1..4");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("led_matrix_pwm_driver: BLANK_CYCLES must be at least 1");
  end

  logic [TW-1:0]       tick_cnt, tick_nxt;
  logic [BPP-1:0]      slot, slot_nxt;
  logic                row_advance;
  logic                frame_wrap;
  logic                in_blank;
  logic [PIX_BITS-1:0] active_red, active_grn;
  logic [PIX_BITS-1:0] pending_red, pending_grn;
  logic                pending_full;

`ifdef LED_ROW_BLANK_EN
  typedef enum logic {SCAN = 1'b0, BLANK = 1'b1} state_t;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  state_t        state, state_nxt;
  logic [BW-1:0] blank_cnt, blank_nxt;

  assign in_blank = (state == BLANK);
`else
  assign in_blank = 1'b0;
`endif

  // Next-state logic: tick -> slot -> (blank) -> row, all gated by enable.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    tick_nxt    = tick_cnt;
    slot_nxt    = slot;
    row_advance = 1'b0;
`ifdef LED_ROW_BLANK_EN
    state_nxt   = state;
    blank_nxt   = blank_cnt;
`endif
    if (enable) begin
`ifdef LED_ROW_BLANK_EN
      if (state == BLANK) begin
        // tick and slot were already zeroed on entry, so leaving BLANK
        // restarts the new row at slot 0, tick 0.
        if (blank_cnt == BLANK_LAST) begin
          state_nxt   = SCAN;
          row_advance = 1'b1;
        end else begin
          blank_nxt = blank_cnt + 1'b1;
        end
      end else
`endif
      begin
        tick_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        if (tick_cnt == TICK_LAST) begin
          if (slot == SLOT_LAST) begin
            slot_nxt = '0;
`ifdef LED_ROW_BLANK_EN
            state_nxt = BLANK;
            blank_nxt = '0;
`else
            row_advance = 1'b1;
`endif
          end else begin
            slot_nxt = slot + 1'b1;
          end
        end
      end
    end
  end

  // Leaving the last row is the frame boundary (swap point).
  assign frame_wrap = row_advance && (row_sel == ROW_LAST);

  // Scan state register: counters, row, FSM state and frame_start pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt    <= '0;
      slot        <= '0;
      row_sel     <= '0;
      frame_start <= 1'b0;
`ifdef LED_ROW_BLANK_EN
      state       <= SCAN;
      blank_cnt   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      tick_cnt    <= tick_nxt;
      slot        <= slot_nxt;
      frame_start <= frame_wrap;
      if (row_advance) begin
        row_sel <= (row_sel == ROW_LAST) ? '0 : row_sel + 1'b1;
      end
`ifdef LED_ROW_BLANK_EN
      state       <= state_nxt;
      blank_cnt   <= blank_nxt;
`endif
    end
  end

  // Frame store: load pending on handshake, swap into active at the boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the frame buffers are reset explicitly because a blank display
      // after reset is required behaviour, not just an initial value.
      active_red   <= '0;
      active_grn   <= '0;
      pending_red  <= '0;
      pending_grn  <= '0;
      pending_full <= 1'b0;
    end else if (frame_valid && !pending_full) begin
      pending_red  <= red_in;
      pending_grn  <= grn_in;
      pending_full <= 1'b1;
    end else if (frame_wrap && pending_full) begin
      active_red   <= pending_red;
      active_grn   <= pending_grn;
      pending_full <= 1'b0;
    end
  end

  assign frame_ready = ~pending_full;
  assign row_blank   = in_blank;

  // Column decode: a pixel is lit while its level exceeds the current slot.
  always_comb begin
    red_col = '0;
    grn_col = '0;
    if (!in_blank) begin
      for (int c = 0; c < COLS; c++) begin
        red_col[c] = active_red[(int'(row_sel) * COLS + c) * BPP +: BPP] > slot;
        grn_col[c] = active_grn[(int'(row_sel) * COLS + c) * BPP +: BPP] > slot;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_pwm_driver.sv
// Self-checking bench for led_matrix_pwm_driver (4x4, BPP=2, FREQDIV=1).
// Row/slot position is derived from a count of enabled cycles since reset;
// frame contents come from a pending/active model updated on clk edges.
// Works with or without LED_ROW_BLANK_EN defined.
module tb_led_matrix_pwm_driver;

  localparam int ROWS = 4, COLS = 4, BPP = 2, FREQDIV = 1, BLANK_CYCLES = 2;
  localparam int W     = ROWS * COLS * BPP;
  localparam int TICK  = 1 << FREQDIV;
  localparam int SLOTS = (1 << BPP) - 1;
`ifdef LED_ROW_BLANK_EN
  localparam int BLANK_T = BLANK_CYCLES;
`else
  localparam int BLANK_T = 0;
`endif
  localparam int P     = SLOTS * TICK + BLANK_T;  // row period: 8 or 6
  localparam int FRAME = ROWS * P;                // frame period: 32 or 24

  logic                    clk, rst, enable, frame_valid, frame_ready;
  logic [W-1:0]            red_in, grn_in;
  logic [$clog2(ROWS)-1:0] row_sel;
  logic [COLS-1:0]         red_col, grn_col;
  logic                    row_blank, frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  led_matrix_pwm_driver #(
    .ROWS(ROWS), .COLS(COLS), .BPP(BPP), .FREQDIV(FREQDIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .red_in(red_in), .grn_in(grn_in),
    .row_sel(row_sel), .red_col(red_col), .grn_col(grn_col),
    .row_blank(row_blank), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: enabled-cycle count plus pending/active frame buffers.
  int           n;
  logic [W-1:0] m_act_r, m_act_g, m_pen_r, m_pen_g;
  logic         m_pfull, m_fs, bnd;

  assign bnd = enable && (((n + 1) % FRAME) == 0);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n       <= 0;
      m_act_r <= '0;
      m_act_g <= '0;
      m_pen_r <= '0;
      m_pen_g <= '0;
      m_pfull <= 1'b0;
      m_fs    <= 1'b0;
    end else begin
      if (frame_valid && !m_pfull) begin
        m_pen_r <= red_in;
        m_pen_g <= grn_in;
        m_pfull <= 1'b1;
      end else if (bnd && m_pfull) begin
        m_act_r <= m_pen_r;
        m_act_g <= m_pen_g;
        m_pfull <= 1'b0;
      end
      if (enable) n <= n + 1;
      m_fs <= bnd;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  task automatic compare();
    int w, row, slot;
    logic blank;
    logic [COLS-1:0] er, eg;
    w     = n % P;
    row   = (n / P) % ROWS;
    slot  = w / TICK;
    blank = (w >= SLOTS * TICK);
    er    = '0;
    eg    = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!blank) begin
        er[c] = int'(m_act_r[(row * COLS + c) * BPP +: BPP]) > slot;
        eg[c] = int'(m_act_g[(row * COLS + c) * BPP +: BPP]) > slot;
      end
    end
    check("row_sel",     32'(row_sel),     32'(row));
    check("red_col",     32'(red_col),     32'(er));
    check("grn_col",     32'(grn_col),     32'(eg));
    check("row_blank",   32'(row_blank),   32'(blank));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("frame_ready", 32'(frame_ready), 32'(!m_pfull));
  endtask

  // One clock cycle: compare on the falling edge, then move to just after
  // the next rising edge where the stimulus changes inputs.
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fs(input string name, output int k);
    k = -1;
    for (int i = 1; i <= 4 * FRAME; i++) begin
      step();
      if (frame_start === 1'b1) begin
        k = i;
        break;
      end
    end
    if (k < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no frame_start within %0d cycles", name, 4 * FRAME);
    end
  endtask

  initial begin
    int k;
    int c_r2, c_g1, c_g3, c_bl, c_other, c_row0;
    logic [W-1:0]    red_b, grn_b;
    logic [COLS-1:0] any_col;

    rst = 1'b0; enable = 1'b1; frame_valid = 1'b0; red_in = '0; grn_in = '0;
    @(posedge clk); #2;
    step(); step();
    check("reset_ready", 32'(frame_ready), 32'h1);
    check("reset_cols",  32'({red_col, grn_col}), 32'h0);

    // 1) idle scan after release: first frame_start one frame in.
    rst = 1'b1;
    wait_fs("first_fs", k);
    check("first_fs_cycle", 32'(k), 32'(FRAME));
    check("first_fs_row",   32'(row_sel), 32'h0);

    // 2) red (0,2)=1 -> bits[5:4]=01; grn (0,1)=3 -> bits[3:2]=11,
    //    grn (0,3)=2 -> bits[7:6]=10.
    red_in = 32'h0000_0010; grn_in = 32'h0000_008C; frame_valid = 1'b1;
    step();
    check("ready_after_load", 32'(frame_ready), 32'h0);
    frame_valid = 1'b0; red_in = '1; grn_in = '1;   // ignored while full
    wait_fs("fs_after_load", k);
    check("ready_after_swap", 32'(frame_ready), 32'h1);
    c_r2 = 0; c_g1 = 0; c_g3 = 0; c_bl = 0; c_other = 0; c_row0 = 0;
    for (int i = 0; i < P; i++) begin
      c_r2    += int'(red_col[2]);
      c_g1    += int'(grn_col[1]);
      c_g3    += int'(grn_col[3]);
      c_bl    += int'(row_blank);
      c_other += int'(red_col[0]) + int'(red_col[1]) + int'(red_col[3])
               + int'(grn_col[0]) + int'(grn_col[2]);
      c_row0  += int'(row_sel == 2'd0);
      step();
    end
    check("row0_red2_cycles",  32'(c_r2),    32'd2);
    check("row0_grn1_cycles",  32'(c_g1),    32'd6);
    check("row0_grn3_cycles",  32'(c_g3),    32'd4);
    check("row0_blank_cycles", 32'(c_bl),    32'(BLANK_T));
    check("row0_other_cycles", 32'(c_other), 32'd0);
    check("row0_length",       32'(c_row0),  32'(P));

    // 3) frame A mid-frame, then frame B held valid while pending is full.
    repeat (3) step();
    red_in = '1; grn_in = '0; frame_valid = 1'b1;
    step();
    check("ready_after_a", 32'(frame_ready), 32'h0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        red_b[(r * COLS + c) * BPP +: BPP] = 2'(c % 4);
        grn_b[(r * COLS + c) * BPP +: BPP] = 2'((r + c) % 4);
      end
    red_in = red_b; grn_in = grn_b;
    repeat (5) step();
    check("ready_held_low", 32'(frame_ready), 32'h0);
    wait_fs("fs_frame_a", k);
    check("a_ready_back", 32'(frame_ready), 32'h1);
    check("a_red_row0",   32'(red_col), 32'hF);
    check("a_grn_row0",   32'(grn_col), 32'h0);
    step();
    check("b_accepted", 32'(frame_ready), 32'h0);
    frame_valid = 1'b0;
    wait_fs("fs_frame_b", k);
    check("b_red_row0_s0", 32'(red_col), 32'b1110);
    check("b_grn_row0_s0", 32'(grn_col), 32'b1110);
    step(); step();
    check("b_red_row0_s1", 32'(red_col), 32'b1100);

    // 4) freeze in row 2, slot 1 for 10 cycles.
    repeat (2 * P) step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("frz_row",   32'(row_sel),     32'd2);
      check("frz_red",   32'(red_col),     32'b1100);
      check("frz_grn",   32'(grn_col),     32'b0011);
      check("frz_blank", 32'(row_blank),   32'h0);
      check("frz_fs",    32'(frame_start), 32'h0);
    end
    enable = 1'b1;
    step();
    check("resume_red_s1", 32'(red_col), 32'b1100);
    check("resume_grn_s1", 32'(grn_col), 32'b0011);
    step();
    check("resume_red_s2", 32'(red_col), 32'b1000);
    check("resume_grn_s2", 32'(grn_col), 32'b0010);

    // 5) asynchronous reset mid-row with a pending frame.
    red_in = {(W/2){2'b01}}; grn_in = '0; frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
    check("pend_before_rst", 32'(frame_ready), 32'h0);
    check("red_before_rst",  32'(red_col), 32'b1000);
    #1 rst = 1'b0;
    #1;
    check("async_row",   32'(row_sel),     32'h0);
    check("async_cols",  32'({red_col, grn_col}), 32'h0);
    check("async_blank", 32'(row_blank),   32'h0);
    check("async_fs",    32'(frame_start), 32'h0);
    check("async_ready", 32'(frame_ready), 32'h1);
    step(); step();
    rst = 1'b1;
    any_col = '0;
    for (int i = 0; i < FRAME + P; i++) begin
      any_col |= red_col | grn_col;
      step();
    end
    check("blank_after_rst", 32'(any_col), 32'h0);
    check("ready_after_rst", 32'(frame_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
